// File: rtl/div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_hilo_ctrl
//  Purpose  : Sequencer between the control unit and the multicycle divider.
//             Registers the operands and pulses the divider start. Waits for
//             done and commits quotient/remainder into LO/HI. Reports
//             divide-by-zero and divider timeout as one-cycle exceptions.
//             Also services MTHI/MTLO writes.
//  Revision : 1.0  initial release
// ============================================================================
module div_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] div_rem,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             busy,
  output logic             ack,
  output logic             exc_dbz,
  output logic             exc_tmo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // The timer must be able to hold TIMEOUT-1; one spare bit keeps it simple.
  localparam int            TIMER_W  = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_ERR_DBZ = 3'd4,
    ST_ERR_TMO = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic                 armed;
  logic                 accept;
  logic                 in_idle;
  logic                 in_wait;
  logic                 ack_state;
  logic                 unused_div_busy;

  // The divider's busy flag carries no control meaning here.
  assign unused_div_busy = div_busy;

  // Qualifiers shared by the state machine and the datapath registers.
  always_comb begin
    in_idle   = (state == ST_IDLE);
    in_wait   = (state == ST_WAIT);
    ack_state = (state == ST_COMMIT) || (state == ST_ERR_DBZ) ||
                (state == ST_ERR_TMO);
    accept    = in_idle && op_div && armed;
  end

  // Next-state logic; a divider result wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done && !div_dbz)  state_nxt = ST_COMMIT;
        else if (div_done)         state_nxt = ST_ERR_DBZ;
        else if (timer == TMO_LAST) state_nxt = ST_ERR_TMO;
      end
      ST_COMMIT:  state_nxt = ST_IDLE;
      ST_ERR_DBZ: state_nxt = ST_IDLE;
      ST_ERR_TMO: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Cycle counter for the wait window, cleared while the start pulse is out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   timer <= '0;
    else if (state == ST_ISSUE) timer <= '0;
    else if (in_wait)           timer <= timer + 1'b1;
  end

  // Re-issue guard: control may still hold op_div in the cycle after ack,
  // so a new request needs op_div to have been seen low first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           armed <= 1'b1;
    else if (!op_div)   armed <= 1'b1;
    else if (ack_state) armed <= 1'b0;
  end

  // Operand registers, held stable until the next accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_a <= '0;
      div_b <= '0;
    end else if (accept) begin
      div_a <= a;
      div_b <= b;
    end
  end

  // HI/LO: software writes only while idle, divider results on success.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (in_idle) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end else if (in_wait && div_done && !div_dbz) begin
      lo <= div_val;
      hi <= div_rem;
    end
  end

  // Status outputs are decoded purely from state.
  always_comb begin
    busy      = !in_idle;
    div_start = (state == ST_ISSUE);
    ack       = ack_state;
    exc_dbz   = (state == ST_ERR_DBZ);
    exc_tmo   = (state == ST_ERR_TMO);
  end

endmodule
`default_nettype wire

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
Sequencer that sits directly downstream of the multicycle divider in the multicycle processor. It accepts a divide request from the main control unit and registers the operands. It pulses the divider's start, waits for done, and commits val/rem into the architectural LO/HI registers. It converts divide-by-zero or a hung divider into a one-cycle exception flag, and also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 64, max cycles in WAIT before abort; must exceed the divider's worst-case latency

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_div  in  1  divide request from control unit; held high until ack
a  in  WIDTH  dividend (rs)
b  in  WIDTH  divisor (rt)
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
div_busy  in  1  from divider (status only)
div_done  in  1  from divider, result valid
div_dbz  in  1  from divider, divisor was zero
div_val  in  WIDTH  quotient from divider
div_rem  in  WIDTH  remainder from divider
div_start  out  1  start pulse to divider
div_a  out  WIDTH  registered dividend to divider
div_b  out  WIDTH  registered divisor to divider
busy  out  1  sequence in progress
ack  out  1  one-cycle completion pulse
exc_dbz  out  1  one-cycle divide-by-zero exception, coincident with ack
exc_tmo  out  1  one-cycle timeout exception, coincident with ack
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=0, async): state IDLE; hi=lo=div_a=div_b=0; div_start=busy=ack=exc_dbz=exc_tmo=0; timer=0; armed=1. Reset mid-sequence aborts silently: no ack, HI/LO cleared.
- All outputs are registered or decoded from state only, with no combinational input→output path.
- The armed flag clears on ack and sets in any cycle op_div=0. A request is accepted only when state=IDLE, op_div=1 and armed=1. This prevents re-issue while control still holds op_div in the ack+1 cycle.
- FSM:
  IDLE: busy=0. On accept, latch div_a<=a and div_b<=b, then go to ISSUE.
  ISSUE: busy=1, div_start=1 for exactly this cycle, timer<=0, then go to WAIT.
  WAIT: busy=1, timer increments each cycle.
    If div_done=1 and div_dbz=0, capture lo<=div_val and hi<=div_rem on this edge, then go to COMMIT.
    If div_done=1 and div_dbz=1, go to ERR_DBZ with HI/LO untouched.
    Otherwise, if timer==TIMEOUT-1, go to ERR_TMO.
    div_done takes priority over timeout when both occur in the same cycle.
  COMMIT: busy=1, ack=1, then go to IDLE.
  ERR_DBZ: busy=1, ack=1, exc_dbz=1, then go to IDLE.
  ERR_TMO: busy=1, ack=1, exc_tmo=1, then go to IDLE.
- Latency: with accept at edge t0, ISSUE occupies cycle t0+1. If the divider asserts done k cycles after the start cycle, ack is high in cycle t0+k+2.
- div_a and div_b are stable from ISSUE through ack.
- Arithmetic: no arithmetic is performed in this block; values are passed through. Signedness is the divider's concern.
- MTHI/MTLO: act only in IDLE, with the write on the same edge. mthi and mtlo may both be high, in which case both registers take wdata. They are dropped silently when state≠IDLE.
- If mthi/mtlo and an accepted op_div occur on the same IDLE edge, the write happens and the later commit overwrites it.
- div_busy is ignored for control; it is used only for bench checks.

Test Plan:
- 7000/7: pulse sequence op_div → exactly one div_start cycle; ack with lo=1000, hi=0, exc_*=0; busy high from ISSUE through ack.
- 9000/-4 (b=0xFFFFFFFC): lo=0xFFFFF736 (-2250), hi=0. Then 9000/7: lo=1285, hi=5. Check the latency formula against a divider model with k=33.
- HI/LO preset via mthi=0x11, mtlo=0x22, then 1000/0: ack with exc_dbz=1, hi=0x11 and lo=0x22 unchanged.
- Stub divider that never asserts done: ack and exc_tmo in cycle t0+TIMEOUT+2, HI/LO unchanged. Then a new request completes normally.
- op_div held high for 3 cycles after ack: no second div_start. Drop op_div for 1 cycle, reassert: new accept. mthi asserted during WAIT: hi unchanged.
- rst pulsed low during WAIT: immediately state IDLE, hi=lo=0, no ack, div_start=0. After release, 5000/3 yields lo=1666, hi=2.
